instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming MIPS instruction encoder. It is the inverse of the control-unit decoder.
- Accepts a mnemonic code plus operand fields over a valid/ready handshake and packs them into 32-bit machine words.
- Emits the words, each with a sequential word address, through a 2-entry output buffer.
- Sits between the bench/boot program generator and the instruction-memory write port.

Parameters:
- ADDR_W, 8, width of the emitted byte address
- BASE, 0, byte address of the first emitted word

Ports:
- Clk  in  1  clock, rising edge
- Clrn  in  1  synchronous active-low reset
- Start  in  1  begin a new program; honoured only in IDLE or DONE
- InValid  in  1  input fields valid
- InReady  out  1  encoder can accept
- Mnem  in  5  mnemonic code (see Behaviour)
- Rs, Rt, Rd, Sa  in  5 each  register fields / shift amount
- Imm  in  16  immediate or branch offset
- Target  in  26  jump word target
- Last  in  1  final instruction of the program
- OutValid  out  1  Instr/Addr valid
- OutReady  in  1  sink accepts the word
- Instr  out  32  encoded word
- Addr  out  ADDR_W  byte address of Instr
- Err  out  1  sticky: illegal mnemonic seen
- Done  out  1  program fully emitted

Behaviour:
- One clock; reset is synchronous, active-low (Clrn sampled on the Clk rising edge).
- Reset values:
  - State=IDLE.
  - Buffer empty, so OutValid=0.
  - InReady=0, Err=0, Done=0.
  - Address counter=0, so Addr=BASE.
  - Instr=0.
  - Reset mid-operation discards buffered words.
- Mnem codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr
  - 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui
  - 18 j, 19 jal
  - 20-31 illegal
- R-type fields: op=000000, word = {op, rs, rt, rd, sa, func}.
  - func: add 100000, sub 100010, and 100100, or 100101, xor 100110.
  - Shift funcs: sll 000000, srl 000010, sra 000011.
  - Shifts force the rs field to 0; all other R-type ops force sa to 0.
  - jr: func 001000; rt, rd and sa forced to 0.
- I-type: word = {op, rs, rt, Imm}.
  - op: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
  - lui forces the rs field to 0.
  - Imm is passed unmodified; no sign handling.
- J-type: word = {op, Target}, op: j 000010, jal 000011.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE: InReady=0. Start leads to RUN.
  - RUN: InReady = (buffer count < 2), computed from registered count only. An accepted transfer with Last=1 leads to FLUSH.
  - FLUSH: InReady=0. When the buffer is empty, go to DONE.
  - DONE: Done=1. Start leads to RUN and clears Err, Done and the address counter.
  - Start in RUN or FLUSH is ignored.
- Encoding is registered.
  - A word accepted at edge N is visible on OutValid/Instr after edge N (latency 1) if the buffer was empty.
  - Otherwise it appears behind the older word.
- Buffer: 2-entry FIFO with in-order output.
  - Simultaneous push and pop keeps the count unchanged.
  - A push is never offered while full, because InReady is low.
- Illegal mnemonic:
  - The transfer is accepted and consumes no buffer slot or address.
  - Err sets on the next edge and stays set until Start or reset.
  - Last on an illegal transfer still moves to FLUSH.
- Addr:
  - Addr = BASE + 4*counter.
  - The counter increments on each OutValid&OutReady.
  - Wraps modulo 2^ADDR_W.
  - Each buffered word stores its own address.
- OutValid, Instr and Addr hold stable while OutValid=1 and OutReady=0.

Test Plan:
- Reset, Start, then add Rs=1 Rt=2 Rd=3 with OutReady=1 → Instr=0x00221820, Addr=BASE, OutValid exactly one cycle after acceptance.
- addi Rs=1 Rt=2 Imm=0xFFFF; sll Rt=1 Rd=2 Sa=4 (with Rs=7 given); lw Rs=29 Rt=8 Imm=4 → 0x2022FFFF, 0x00011100 (rs ignored), 0x8FA80004, at Addr 0, 4, 8.
- j Target=0x10, jal Target=0x3 (Last) → 0x08000010, 0x0C000003; FSM goes FLUSH then DONE; Done=1 after the second word pops.
- Backpressure: OutReady=0 with 3 inputs offered → InReady drops after 2 accepted; words hold stable; after OutReady=1 all 3 emerge in order with contiguous addresses.
- Mnem=25 between two legal ops → Err=1, no word emitted for it, addresses of the legal words contiguous; a following Start clears Err and resets Addr to BASE.
- ADDR_W=4, 5 words emitted → addresses 0, 4, 8, 12, 0. Clrn=0 asserted with 2 words buffered → OutValid=0, state IDLE next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: packs mnemonic + operand fields into
// 32-bit machine words and emits them, with sequential byte addresses,
// through a 2-entry in-order output buffer.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        Mnem,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Sa,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  input  logic              Last,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] Addr,
  output logic              Err,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE);
  localparam logic [ADDR_W-3:0] L_ONE  = (ADDR_W-2)'(1);

  state_t            r_state;
  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [31:0]       r_buf_instr [2];
  logic [ADDR_W-1:0] r_buf_addr  [2];
  // Word counter: number of legal words pushed since Start. Because the
  // buffer is in-order, it equals the popped count whenever the buffer is
  // empty, so it doubles as the emitted-address counter.
  logic [ADDR_W-3:0] r_wr_cnt;
  logic              r_err;

  logic              w_legal;
  logic [31:0]       w_word;
  logic [32:0]       w_enc;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [ADDR_W-1:0] w_push_addr;

  // Returns {legal, word}; illegal mnemonics return legal=0 and a zero word.
  function automatic logic [32:0] encode(
    input logic [4:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sa,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic        legal;
    logic [31:0] word;
    legal = 1'b1;
    word  = 32'h0000_0000;
    case (mnem)
      5'd0:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};   // add
      5'd1:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};   // sub
      5'd2:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};   // and
      5'd3:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};   // or
      5'd4:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100110};   // xor
      5'd5:  word = {6'b000000, 5'd0, rt, rd, sa, 6'b000000};   // sll
      5'd6:  word = {6'b000000, 5'd0, rt, rd, sa, 6'b000010};   // srl
      5'd7:  word = {6'b000000, 5'd0, rt, rd, sa, 6'b000011};   // sra
      5'd8:  word = {6'b000000, rs, 15'd0, 6'b001000};          // jr
      5'd9:  word = {6'b001000, rs, rt, imm};                   // addi
      5'd10: word = {6'b001100, rs, rt, imm};                   // andi
      5'd11: word = {6'b001101, rs, rt, imm};                   // ori
      5'd12: word = {6'b001110, rs, rt, imm};                   // xori
      5'd13: word = {6'b100011, rs, rt, imm};                   // lw
      5'd14: word = {6'b101011, rs, rt, imm};                   // sw
      5'd15: word = {6'b000100, rs, rt, imm};                   // beq
      5'd16: word = {6'b000101, rs, rt, imm};                   // bne
      5'd17: word = {6'b001111, 5'd0, rt, imm};                 // lui
      5'd18: word = {6'b000010, target};                        // j
      5'd19: word = {6'b000011, target};                        // jal
      default: begin
        legal = 1'b0;
        word  = 32'h0000_0000;
      end
    endcase
    return {legal, word};
  endfunction

  assign w_enc       = encode(Mnem, Rs, Rt, Rd, Sa, Imm, Target);
  assign w_legal     = w_enc[32];
  assign w_word      = w_enc[31:0];

  // Ready depends only on registered state/count, never on OutReady.
  assign w_in_ready  = (r_state == S_RUN) && (r_count != 2'd2);
  assign w_accept    = InValid && w_in_ready;
  assign w_push      = w_accept && w_legal;
  assign w_nonempty  = (r_count != 2'd0);
  assign w_pop       = w_nonempty && OutReady;
  assign w_push_addr = L_BASE + {r_wr_cnt, 2'b00};

  assign InReady  = w_in_ready;
  assign OutValid = w_nonempty;
  assign Instr    = w_nonempty ? r_buf_instr[r_rd_ptr] : 32'h0000_0000;
  assign Addr     = w_nonempty ? r_buf_addr[r_rd_ptr]  : w_push_addr;
  assign Err      = r_err;
  assign Done     = (r_state == S_DONE);

  // Control FSM, output buffer, word counter and sticky error flag.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      r_state        <= S_IDLE;
      r_count        <= 2'd0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_buf_instr[0] <= 32'h0000_0000;
      r_buf_instr[1] <= 32'h0000_0000;
      r_buf_addr[0]  <= '0;
      r_buf_addr[1]  <= '0;
      r_wr_cnt       <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_push) begin
        r_buf_instr[r_wr_ptr] <= w_word;
        r_buf_addr[r_wr_ptr]  <= w_push_addr;
        r_wr_ptr              <= ~r_wr_ptr;
        r_wr_cnt              <= r_wr_cnt + L_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state  <= S_RUN;
            r_err    <= 1'b0;
            r_wr_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_accept && Last) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_count == 2'd0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (Start) begin
            r_state  <= S_RUN;
            r_err    <= 1'b0;
            r_wr_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder (ADDR_W=8 main instance,
// ADDR_W=4 instance sharing the stimulus for address wrap).
module tb_instr_encoder;

  typedef struct {
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic [31:0] exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Clrn, Start, InValid, Last, OutReady;
  logic [4:0]  Mnem, Rs, Rt, Rd, Sa;
  logic [15:0] Imm;
  logic [25:0] Target;
  logic        InReady, OutValid, Err, Done;
  logic [31:0] Instr;
  logic [7:0]  Addr;
  logic        InReady4, OutValid4, Err4, Done4;
  logic [31:0] Instr4;
  logic [3:0]  Addr4;

  int n_chk = 0;
  int n_err = 0;
  vec_t tbl [20];

  instr_encoder #(.ADDR_W(8), .BASE(0)) dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .InValid(InValid), .InReady(InReady),
    .Mnem(Mnem), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Sa(Sa), .Imm(Imm), .Target(Target),
    .Last(Last), .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr),
    .Addr(Addr), .Err(Err), .Done(Done)
  );

  instr_encoder #(.ADDR_W(4), .BASE(0)) dut4 (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .InValid(InValid), .InReady(InReady4),
    .Mnem(Mnem), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Sa(Sa), .Imm(Imm), .Target(Target),
    .Last(Last), .OutValid(OutValid4), .OutReady(OutReady), .Instr(Instr4),
    .Addr(Addr4), .Err(Err4), .Done(Done4)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic [4:0] m, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] sa, input logic [15:0] imm,
                              input logic [25:0] tgt, input logic last,
                              input logic [31:0] exp);
    vec_t v;
    v.mnem = m; v.rs = rs; v.rt = rt; v.rd = rd; v.sa = sa;
    v.imm = imm; v.tgt = tgt; v.last = last; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    Mnem = v.mnem; Rs = v.rs; Rt = v.rt; Rd = v.rd; Sa = v.sa;
    Imm = v.imm; Target = v.tgt; Last = v.last;
  endtask

  // One transfer, accepted on the next rising edge; optional output check after it.
  task automatic send(input vec_t v, input bit chk, input logic [7:0] ea);
    @(negedge Clk);
    drive(v);
    InValid = 1'b1;
    check("in_ready", {31'd0, InReady}, 32'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    Last    = 1'b0;
    if (chk) begin
      check("out_valid", {31'd0, OutValid}, 32'd1);
      check("instr", Instr, v.exp);
      check("addr", {24'd0, Addr}, {24'd0, ea});
      check("addr4", {28'd0, Addr4}, {28'd0, ea[3:0]});
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 8; i++) begin
      if (Done) break;
      @(posedge Clk);
      #1;
    end
    check("done", {31'd0, Done}, 32'd1);
    check("done_in_ready", {31'd0, InReady}, 32'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(5'd0,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'h0,       1'b0, 32'h00221820);
    tbl[1]  = mk(5'd1,  5'd4,  5'd5, 5'd6, 5'd3, 16'h0000, 26'h0,       1'b0, 32'h00853022);
    tbl[2]  = mk(5'd2,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'h0,       1'b0, 32'h00221824);
    tbl[3]  = mk(5'd3,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'h0,       1'b0, 32'h00221825);
    tbl[4]  = mk(5'd4,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'h0,       1'b0, 32'h00221826);
    tbl[5]  = mk(5'd5,  5'd7,  5'd1, 5'd2, 5'd4, 16'h0000, 26'h0,       1'b0, 32'h00011100);
    tbl[6]  = mk(5'd6,  5'd7,  5'd1, 5'd2, 5'd4, 16'h0000, 26'h0,       1'b0, 32'h00011102);
    tbl[7]  = mk(5'd7,  5'd7,  5'd1, 5'd2, 5'd4, 16'h0000, 26'h0,       1'b0, 32'h00011103);
    tbl[8]  = mk(5'd8,  5'd31, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0,       1'b0, 32'h03E00008);
    tbl[9]  = mk(5'd9,  5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0,       1'b0, 32'h2022FFFF);
    tbl[10] = mk(5'd10, 5'd1,  5'd2, 5'd0, 5'd0, 16'h00F0, 26'h0,       1'b0, 32'h302200F0);
    tbl[11] = mk(5'd11, 5'd1,  5'd2, 5'd0, 5'd0, 16'h00F0, 26'h0,       1'b0, 32'h342200F0);
    tbl[12] = mk(5'd12, 5'd1,  5'd2, 5'd0, 5'd0, 16'h00F0, 26'h0,       1'b0, 32'h382200F0);
    tbl[13] = mk(5'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0,       1'b0, 32'h8FA80004);
    tbl[14] = mk(5'd14, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0,       1'b0, 32'hAFA80004);
    tbl[15] = mk(5'd15, 5'd1,  5'd2, 5'd0, 5'd0, 16'h8000, 26'h0,       1'b0, 32'h10228000);
    tbl[16] = mk(5'd16, 5'd1,  5'd2, 5'd0, 5'd0, 16'h8000, 26'h0,       1'b0, 32'h14228000);
    tbl[17] = mk(5'd17, 5'd5,  5'd3, 5'd0, 5'd0, 16'h1234, 26'h0,       1'b0, 32'h3C031234);
    tbl[18] = mk(5'd18, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h10,      1'b0, 32'h08000010);
    tbl[19] = mk(5'd19, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h3,       1'b1, 32'h0C000003);

    Clrn = 1'b0; Start = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    drive(tbl[0]);
    Last = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out_valid", {31'd0, OutValid}, 32'd0);
    check("rst_in_ready", {31'd0, InReady}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_addr", {24'd0, Addr}, 32'd0);
    check("rst_instr", Instr, 32'd0);
    @(negedge Clk);
    Clrn = 1'b1;
    @(posedge Clk);
    #1;
    check("idle_in_ready", {31'd0, InReady}, 32'd0);

    // Every mnemonic, back to back, one word per cycle; jal carries Last.
    pulse_start();
    check("run_in_ready", {31'd0, InReady}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      send(tbl[i], 1'b1, 8'(4 * i));
    end
    wait_done();

    // Backpressure: two fill the buffer, the third waits for space.
    pulse_start();
    check("restart_done", {31'd0, Done}, 32'd0);
    check("restart_addr", {24'd0, Addr}, 32'd0);
    OutReady = 1'b0;
    send(tbl[0], 1'b1, 8'd0);
    send(tbl[9], 1'b0, 8'd0);
    @(negedge Clk);
    v = tbl[13];
    v.last = 1'b1;
    drive(v);
    InValid = 1'b1;
    check("bp_full_in_ready", {31'd0, InReady}, 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    check("bp_hold_valid", {31'd0, OutValid}, 32'd1);
    check("bp_hold_instr", Instr, tbl[0].exp);
    check("bp_hold_addr", {24'd0, Addr}, 32'd0);
    @(negedge Clk);
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    check("bp_w1_instr", Instr, tbl[9].exp);
    check("bp_w1_addr", {24'd0, Addr}, 32'd4);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    Last    = 1'b0;
    check("bp_w2_instr", Instr, tbl[13].exp);
    check("bp_w2_addr", {24'd0, Addr}, 32'd8);
    wait_done();

    // Illegal mnemonic between two legal ones.
    pulse_start();
    send(tbl[0], 1'b1, 8'd0);
    v = tbl[0];
    v.mnem = 5'd25;
    send(v, 1'b0, 8'd0);
    check("ill_no_word", {31'd0, OutValid}, 32'd0);
    @(posedge Clk);
    #1;
    check("ill_err", {31'd0, Err}, 32'd1);
    v = tbl[9];
    v.last = 1'b1;
    send(v, 1'b1, 8'd4);
    wait_done();
    check("ill_err_sticky", {31'd0, Err}, 32'd1);
    pulse_start();
    check("start_clr_err", {31'd0, Err}, 32'd0);
    check("start_clr_addr", {24'd0, Addr}, 32'd0);

    // Five words: ADDR_W=4 instance wraps to 0 on the fifth.
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      v.last = (i == 4);
      send(v, 1'b1, 8'(4 * i));
    end
    wait_done();

    // Reset with two words buffered discards them.
    pulse_start();
    OutReady = 1'b0;
    send(tbl[2], 1'b1, 8'd0);
    send(tbl[3], 1'b0, 8'd0);
    check("pre_rst_valid", {31'd0, OutValid}, 32'd1);
    @(negedge Clk);
    Clrn = 1'b0;
    @(posedge Clk);
    #1;
    check("mid_rst_valid", {31'd0, OutValid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, InReady}, 32'd0);
    check("mid_rst_addr", {24'd0, Addr}, 32'd0);
    check("mid_rst_instr", Instr, 32'd0);
    @(negedge Clk);
    Clrn = 1'b1;
    @(posedge Clk);
    #1;
    check("post_rst_idle", {31'd0, InReady}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
